// File: rtl/fir_xifu_mem_resp.sv
`default_nettype none
// ============================================================================
// Module      : fir_xifu_mem_resp
// Description : X-IF coprocessor memory-request responder. Checks each request
//               for size legality and alignment, replies with an exception in
//               the accept cycle, otherwise issues one single-beat transfer on
//               the data bus and returns the raw 32-bit word as a result.
//               At most one transaction is outstanding at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_xifu_mem_resp #(
    parameter int ID_WIDTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clear_i,

    // coprocessor memory request
    input  logic                mem_valid_i,
    output logic                mem_ready_o,
    input  logic [ID_WIDTH-1:0] mem_id_i,
    input  logic [31:0]         mem_addr_i,
    input  logic                mem_we_i,
    input  logic [2:0]          mem_size_i,
    input  logic [3:0]          mem_be_i,
    input  logic [31:0]         mem_wdata_i,
    input  logic                mem_last_i,

    // request response (accept cycle only)
    output logic                mem_resp_exc_o,
    output logic [5:0]          mem_resp_exccode_o,

    // transaction result
    output logic                mem_result_valid_o,
    output logic [ID_WIDTH-1:0] mem_result_id_o,
    output logic [31:0]         mem_result_rdata_o,
    output logic                mem_result_err_o,

    // data bus request channel
    output logic                data_req_o,
    input  logic                data_gnt_i,
    output logic [31:0]         data_addr_o,
    output logic                data_we_o,
    output logic [3:0]          data_be_o,
    output logic [31:0]         data_wdata_o,

    // data bus response channel
    input  logic                data_rvalid_i,
    input  logic [31:0]         data_rdata_i,
    input  logic                data_err_i
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUS_REQ  = 2'd1,
        BUS_WAIT = 2'd2,
        RESULT   = 2'd3
    } state_e;

    localparam logic [5:0] EXC_LOAD_MISALIGN  = 6'd4;
    localparam logic [5:0] EXC_STORE_MISALIGN = 6'd6;

    state_e                state_q, state_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [29:0]           addr_q, addr_d;     // word address; byte offset is never driven out
    logic                  we_q, we_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  squash_q, squash_d; // result of the outstanding transfer must be dropped

    logic                  size_byte;
    logic                  size_half;
    logic                  size_word;
    logic                  size_illegal;
    logic                  misaligned;
    logic                  req_exc;
    logic                  accept;

    // Multi-beat sequencing is not supported, so the last-beat flag carries no meaning here.
    logic                  unused_last;
    assign unused_last = mem_last_i;

    // Classify the incoming request: one-hot size decode and natural alignment.
    always_comb begin
        size_byte    = (mem_size_i == 3'b001);
        size_half    = (mem_size_i == 3'b010);
        size_word    = (mem_size_i == 3'b100);
        size_illegal = ~(size_byte | size_half | size_word);
        misaligned   = (size_half & mem_addr_i[0]) | (size_word & (|mem_addr_i[1:0]));
        req_exc      = size_illegal | misaligned;
        accept       = mem_valid_i & (state_q == IDLE);
    end

    // Next-state and latched-field update for the single-outstanding transaction.
    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        we_d     = we_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        squash_d = squash_q;

        case (state_q)
            IDLE: begin
                // A faulting request is answered in place and never reaches the bus.
                if (accept && !req_exc) begin
                    id_d     = mem_id_i;
                    addr_d   = mem_addr_i[31:2];
                    we_d     = mem_we_i;
                    be_d     = mem_be_i;
                    wdata_d  = mem_wdata_i;
                    squash_d = 1'b0;
                    state_d  = BUS_REQ;
                end
            end
            BUS_REQ: begin
                // Once granted the bus owes us a response, so a flush can only
                // mark the result as dropped; without a grant we can simply withdraw.
                if (data_gnt_i) begin
                    squash_d = clear_i;
                    state_d  = BUS_WAIT;
                end else if (clear_i) begin
                    state_d  = IDLE;
                end
            end
            BUS_WAIT: begin
                if (clear_i) begin
                    squash_d = 1'b1;
                end
                if (data_rvalid_i) begin
                    rdata_d = we_q ? 32'd0 : data_rdata_i;
                    err_d   = data_err_i;
                    state_d = (squash_q || clear_i) ? IDLE : RESULT;
                end
            end
            RESULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode; data bus is quiet outside the request phase.
    always_comb begin
        mem_ready_o        = (state_q == IDLE);
        mem_resp_exc_o     = accept & req_exc;
        mem_resp_exccode_o = 6'd0;
        if (accept && req_exc) begin
            mem_resp_exccode_o = mem_we_i ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN;
        end

        mem_result_valid_o = (state_q == RESULT) & ~clear_i;
        mem_result_id_o    = '0;
        mem_result_rdata_o = 32'd0;
        mem_result_err_o   = 1'b0;
        if (mem_result_valid_o) begin
            mem_result_id_o    = id_q;
            mem_result_rdata_o = rdata_q;
            mem_result_err_o   = err_q;
        end

        data_req_o   = 1'b0;
        data_addr_o  = 32'd0;
        data_we_o    = 1'b0;
        data_be_o    = 4'd0;
        data_wdata_o = 32'd0;
        if (state_q == BUS_REQ) begin
            data_req_o   = 1'b1;
            data_addr_o  = {addr_q, 2'b00};
            data_we_o    = we_q;
            data_be_o    = be_q;
            data_wdata_o = wdata_q;
        end
    end

    // State register with synchronous active-low reset; reset aborts any transfer.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            id_q     <= '0;
            addr_q   <= 30'd0;
            we_q     <= 1'b0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
            squash_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            squash_q <= squash_d;
        end
    end

endmodule
`default_nettype wire
